dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port synchronous data memory between the MCU core (port C) and the DMA/loader engine (port D). It grants ownership one requester at a time, issues that owner's read/write commands onto the memory port, and returns read data with a registered valid strobe. A hold counter bounds consecutive accesses so neither port can starve the other. The block sits between the core/DMA and the DMEM macro, upstream of the address/data muxing of the memory interface.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MCU core (port C), the DMA/loader (port D), the
// DMEM macro and the arbiter that shares the memory between them.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory macro.
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Grants the single-port DMEM to the core or the DMA one owner at a time,
// bounding each tenure with a hold counter and routing read returns back.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input logic           clk_i,
    input logic           rst_ni,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OWN_C = 2'd1;
    localparam logic [1:0] ST_OWN_D = 2'd2;

    localparam logic LAST_C = 1'b0;
    localparam logic LAST_D = 1'b1;

    // One spare code above MAX_HOLD so the incremented count never wraps.
    localparam int              CNT_W    = $clog2(MAX_HOLD + 2);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             c_rvalid_q, c_rvalid_d;
    logic             d_rvalid_q, d_rvalid_d;

    logic             own_c, own_d;
    logic             c_acc, d_acc;
    logic             req_own, req_oth;
    logic             limit;
    logic [CNT_W-1:0] hold_inc;

    assign own_c    = (state_q == ST_OWN_C);
    assign own_d    = (state_q == ST_OWN_D);
    assign c_acc    = own_c & bus.c_req;
    assign d_acc    = own_d & bus.d_req;
    assign req_own  = own_c ? bus.c_req : bus.d_req;
    assign req_oth  = own_c ? bus.d_req : bus.c_req;
    assign hold_inc = hold_q + 1'b1;
    assign limit    = (hold_inc >= HOLD_MAX);

    assign bus.c_gnt    = own_c;
    assign bus.d_gnt    = own_d;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.c_rdata  = c_rvalid_q ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.d_rdata  = d_rvalid_q ? bus.mem_rdata : {DATA_W{1'b0}};

    // Memory command follows the registered owner, so reset silences it at once.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        bus.mem_en    = c_acc | d_acc;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_wdata = {DATA_W{1'b0}};
        if (own_c) begin
            bus.mem_we    = bus.c_we;
            bus.mem_addr  = bus.c_addr;
            bus.mem_wdata = bus.c_wdata;
        end else if (own_d) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        if (own_c || own_d) begin
            if (!req_own || (limit && req_oth)) begin
                if (req_oth) state_d = own_c ? ST_OWN_D : ST_OWN_C;
                else         state_d = ST_IDLE;
                last_d = own_c ? LAST_C : LAST_D;
                hold_d = '0;
            end else begin
                hold_d = limit ? HOLD_MAX : hold_inc;
            end
        end else begin
            // The port that did not release last wins a tie.
            hold_d = '0;
            if (bus.c_req && bus.d_req)
                state_d = (last_q == LAST_D) ? ST_OWN_C : ST_OWN_D;
            else if (bus.c_req)
                state_d = ST_OWN_C;
            else if (bus.d_req)
                state_d = ST_OWN_D;
            else
                state_d = ST_IDLE;
        end
    end

    // Return strobe is tagged with the issuing port, independent of later handover.
    assign c_rvalid_d = c_acc & ~bus.c_we;
    assign d_rvalid_d = d_acc & ~bus.d_we;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            last_q     <= LAST_D;
            hold_q     <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_q     <= hold_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared every cycle against a port-level ownership model and memory image.
module tb_dmem_arbiter;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst_ni;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Environment memory answers the DUT bus; the reference image follows the model.
    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];
    logic       env_rd_pend;
    logic [7:0] env_rd_data;

    // Model: owner -1 none / 0 core / 1 DMA; streak counts accesses this tenure.
    logic       in_req [2];
    logic       in_we  [2];
    logic [7:0] in_addr  [2];
    logic [7:0] in_wdata [2];
    int         m_owner;
    int         m_last;
    int         m_streak;
    int         m_rv_port;
    logic [7:0] m_rv_data;

    logic        drive_rst;
    logic [37:0] exp_vec;
    logic [37:0] obs_vec;
    int          acc_port;
    int          vectors;
    int          miscompares;
    int          step_no;

    task automatic model_update();
        int o;
        int y;
        o = m_owner;
        m_rv_port = -1;
        if (o >= 0 && in_req[o]) begin
            if (in_we[o]) ref_mem[in_addr[o]] = in_wdata[o];
            else begin
                m_rv_port = o;
                m_rv_data = ref_mem[in_addr[o]];
            end
        end
        if (o < 0) begin
            m_streak = 0;
            if (in_req[0] && in_req[1]) m_owner = 1 - m_last;
            else if (in_req[0])         m_owner = 0;
            else if (in_req[1])         m_owner = 1;
        end else begin
            y = 1 - o;
            if (!in_req[o]) begin
                m_last   = o;
                m_owner  = in_req[y] ? y : -1;
                m_streak = 0;
            end else begin
                m_streak++;
                if (m_streak >= MAX_HOLD && in_req[y]) begin
                    m_last   = o;
                    m_owner  = y;
                    m_streak = 0;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit later, advance model.
    task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd);
        logic       e_en, e_we;
        logic [7:0] e_addr, e_wd;
        logic       e_rv [2];
        logic [7:0] e_rd [2];
        @(negedge clk);
        step_no++;
        rst_ni = drive_rst;
        in_req[0] = cr; in_we[0] = cw; in_addr[0] = ca; in_wdata[0] = cd;
        in_req[1] = dr; in_we[1] = dw; in_addr[1] = da; in_wdata[1] = dd;
        bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
        bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
        bus.mem_rdata = env_rd_pend ? env_rd_data : 8'($urandom);
        if (!drive_rst) begin
            m_owner = -1; m_last = 1; m_streak = 0; m_rv_port = -1;
            env_rd_pend = 1'b0;
        end
        #1;
        e_en = 1'b0; e_we = 1'b0; e_addr = 8'h00; e_wd = 8'h00;
        if (m_owner >= 0) begin
            e_en   = in_req[m_owner];
            e_we   = in_we[m_owner];
            e_addr = in_addr[m_owner];
            e_wd   = in_wdata[m_owner];
        end
        for (int p = 0; p < 2; p++) begin
            e_rv[p] = (m_rv_port == p);
            e_rd[p] = e_rv[p] ? m_rv_data : 8'h00;
        end
        exp_vec = {m_owner == 0, m_owner == 1, e_en, e_we, e_addr, e_wd,
                   e_rv[0], e_rd[0], e_rv[1], e_rd[1]};
        obs_vec = {bus.c_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                   bus.c_rvalid, bus.c_rdata, bus.d_rvalid, bus.d_rdata};
        acc_port = (bus.mem_en === 1'b1) ? ((bus.c_gnt === 1'b1) ? 0 : 1) : -1;
        env_rd_pend = 1'b0;
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) env_mem[bus.mem_addr] = bus.mem_wdata;
            else begin
                env_rd_pend = 1'b1;
                env_rd_data = env_mem[bus.mem_addr];
            end
        end
        if (drive_rst) model_update();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL idle step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_reset();
        drive_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 8'($urandom), 8'h00, 1, 0, 8'($urandom), 8'h00);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_hold step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
        end
        drive_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 8'($urandom), 8'h00, 1, 0, 8'($urandom), 8'h00);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL reset_release step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
        end
        vectors++;
        if ({bus.c_gnt, bus.d_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL first_tie: gnt c/d got %b want 10", {bus.c_gnt, bus.d_gnt});
        end
        idle_cycles(2);
    endtask

    task automatic test_c_read();
        env_mem[8'h10] = 8'hA5;
        ref_mem[8'h10] = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
            else       step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL c_read step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
            if (i == 1) begin
                vectors++;
                if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
                    miscompares++;
                    $display("FAIL c_read_issue: en/we/addr got %b/%b/%h want 1/0/10",
                             bus.mem_en, bus.mem_we, bus.mem_addr);
                end
            end
        end
        vectors++;
        if ({bus.c_rvalid, bus.c_rdata} !== {1'b1, 8'hA5}) begin
            miscompares++;
            $display("FAIL c_read_return: rvalid/rdata got %b/%h want 1/a5", bus.c_rvalid, bus.c_rdata);
        end
        idle_cycles(2);
    endtask

    task automatic test_hold_limit();
        int seq [$];
        int want;
        step(1, 1, 8'h00, 8'($urandom), 0, 0, 8'h00, 8'h00);
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL hold_grant step %0d: got %h want %h", step_no, obs_vec, exp_vec);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(i), 8'($urandom), 1, 1, 8'(64 + i), 8'($urandom));
            seq.push_back(acc_port);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL hold_limit step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
        end
        for (int i = 0; i < 20; i++) begin
            want = ((i / MAX_HOLD) % 2 == 0) ? 0 : 1;
            vectors++;
            if (seq[i] != want) begin
                miscompares++;
                $display("FAIL hold_sequence access %0d: owner got %0d want %0d", i, seq[i], want);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_solo_saturate();
        int c_count;
        c_count = 0;
        step(1, 0, 8'($urandom), 8'h00, 0, 0, 8'h00, 8'h00);
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL solo_grant step %0d: got %h want %h", step_no, obs_vec, exp_vec);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 1'($urandom), 8'($urandom), 8'($urandom), 0, 0, 8'h00, 8'h00);
            if (acc_port == 0 && bus.c_gnt === 1'b1) c_count++;
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL solo step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
        end
        vectors++;
        if (c_count != 10) begin
            miscompares++;
            $display("FAIL solo_count: core accesses got %0d want 10", c_count);
        end
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 8'($urandom), 8'($urandom), 1, 1, 8'($urandom), 8'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL saturate step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
            vectors++;
            if (acc_port != i) begin
                miscompares++;
                $display("FAIL saturate_owner %0d: owner got %0d want %0d", i, acc_port, i);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_handover_read();
        step(1, 0, 8'($urandom), 8'h00, 0, 0, 8'h00, 8'h00);
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL handover_grant step %0d: got %h want %h", step_no, obs_vec, exp_vec);
        end
        for (int i = 0; i < MAX_HOLD + 1; i++) begin
            step(1, 0, 8'($urandom), 8'h00, 1, 0, 8'($urandom), 8'h00);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL handover step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
        end
        vectors++;
        if ({bus.d_gnt, bus.c_rvalid, bus.d_rvalid} !== 3'b110) begin
            miscompares++;
            $display("FAIL handover_return: d_gnt/c_rvalid/d_rvalid got %b want 110",
                     {bus.d_gnt, bus.c_rvalid, bus.d_rvalid});
        end
        idle_cycles(2);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) begin
            drive_rst = !(i == 3 || i == 4);
            if (i < 5) step(1, 0, 8'($urandom), 8'h00, 0, 0, 8'h00, 8'h00);
            else       step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL mid_reset step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
            if (i >= 3) begin
                vectors++;
                if ({bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_en} !== 5'b0) begin
                    miscompares++;
                    $display("FAIL mid_reset_quiet %0d: gnt/rvalid/en got %b want 00000", i,
                             {bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid, bus.mem_en});
                end
            end
        end
        drive_rst = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_random();
        logic cr, dr;
        cr = 1'b0;
        dr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cr = ~cr;
            if ($urandom_range(0, 3) == 0) dr = ~dr;
            step(cr, 1'($urandom), 8'($urandom), 8'($urandom),
                 dr, 1'($urandom), 8'($urandom), 8'($urandom));
            vectors++;
            if (obs_vec !== exp_vec) begin
                miscompares++;
                $display("FAIL random step %0d: got %h want %h", step_no, obs_vec, exp_vec);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        step_no     = 0;
        drive_rst   = 1'b0;
        rst_ni      = 1'b0;
        env_rd_pend = 1'b0;
        env_rd_data = 8'h00;
        m_owner = -1; m_last = 1; m_streak = 0; m_rv_port = -1; m_rv_data = 8'h00;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = 8'h00; bus.c_wdata = 8'h00;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
        bus.mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end

        test_reset();
        test_c_read();
        test_hold_limit();
        test_solo_saturate();
        test_handover_read();
        test_mid_reset();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
